// File: rtl/vga_capture.sv
// Measures one armed VGA frame (pixels/line, lines, R checksum) behind an 8-bit register port.
// Optional line/frame size checker enabled by defining VGA_CAP_ERRCHK_EN.
module vga_capture #(
    parameter int HACTIVE = 640,
    parameter int VACTIVE = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipselect,
    input  logic       write,
    input  logic       read,
    input  logic [2:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    input  logic       vga_clk,
    input  logic       vga_hs,
    input  logic       vga_vs,
    input  logic       vga_blank_n,
    input  logic [7:0] vga_r
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic        clk_s1_q, clk_s2_q;
    logic        vs_s1_q, vs_s2_q;
    logic        blank_s1_q, blank_s2_q;
    logic [7:0]  r_s1_q;
    logic        busy_q, done_q;
    logic [10:0] hact_q, line_pix_q, line_pix_d;
    logic [9:0]  vact_q, lines_q, lines_d;
    logic [15:0] csum_q, csum_d;
    logic [7:0]  frame_cnt_q;
    logic        err_bit;
    logic [7:0]  rd_d;

    logic pix, vs_rise, vs_fall, blank_fall, arm, line_end;

    // hsync carries no information the measurement needs; parameters only feed the checker
    logic unused_ok;
    assign unused_ok = ^{vga_hs, writedata[7:1], 11'(HACTIVE), 10'(VACTIVE)};

    assign pix        = clk_s1_q & ~clk_s2_q & blank_s1_q;
    assign vs_rise    = vs_s1_q & ~vs_s2_q;
    assign vs_fall    = ~vs_s1_q & vs_s2_q;
    assign blank_fall = ~blank_s1_q & blank_s2_q;
    assign arm        = chipselect & write & (address == 3'd0) & writedata[0];

    // A pixel landing in the same cycle as the line end is folded into that line.
    always_comb begin
        line_pix_d = line_pix_q;
        if (pix && line_pix_q != 11'h7FF)
            line_pix_d = line_pix_q + 11'd1;
        line_end = blank_fall && (line_pix_d != 11'd0);
        lines_d = lines_q;
        if (line_end && lines_q != 10'h3FF)
            lines_d = lines_q + 10'd1;
        csum_d = pix ? csum_q + {8'h00, r_s1_q} : csum_q;
    end

`ifdef VGA_CAP_ERRCHK_EN
    localparam logic [10:0] HACT_W = 11'(HACTIVE);
    localparam logic [9:0]  VACT_W = 10'(VACTIVE);
    logic err_q;
    assign err_bit = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
            err_q <= 1'b0;
        end else if (state_q == S_CAPTURE) begin
            if (line_end && line_pix_d != HACT_W)
                err_q <= 1'b1;
            if (vs_fall && lines_d != VACT_W)
                err_q <= 1'b1;
        end
    end
`else
    assign err_bit = 1'b0;
`endif

    always_comb begin
        rd_d = 8'h00;
        case (address)
            3'd0: rd_d = {5'b0, err_bit, busy_q, done_q};
            3'd1: rd_d = {5'b0, hact_q[10:8]};
            3'd2: rd_d = hact_q[7:0];
            3'd3: rd_d = {6'b0, vact_q[9:8]};
            3'd4: rd_d = vact_q[7:0];
            3'd5: rd_d = csum_q[15:8];
            3'd6: rd_d = csum_q[7:0];
            default: rd_d = frame_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_s1_q    <= 1'b0;
            clk_s2_q    <= 1'b0;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            blank_s1_q  <= 1'b0;
            blank_s2_q  <= 1'b0;
            r_s1_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hact_q      <= 11'd0;
            vact_q      <= 10'd0;
            csum_q      <= 16'd0;
            frame_cnt_q <= 8'd0;
            line_pix_q  <= 11'd0;
            lines_q     <= 10'd0;
            readdata    <= 8'h00;
        end else begin
            clk_s1_q   <= vga_clk;
            clk_s2_q   <= clk_s1_q;
            vs_s1_q    <= vga_vs;
            vs_s2_q    <= vs_s1_q;
            blank_s1_q <= vga_blank_n;
            blank_s2_q <= blank_s1_q;
            r_s1_q     <= vga_r;
            if (chipselect && read)
                readdata <= rd_d;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        line_pix_q <= 11'd0;
                        lines_q    <= 10'd0;
                        csum_q     <= 16'd0;
                        hact_q     <= 11'd0;
                        vact_q     <= 10'd0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= S_WAIT_VS;
                    end
                end
                S_WAIT_VS: begin
                    if (vs_rise)
                        state_q <= S_CAPTURE;
                end
                default: begin
                    csum_q     <= csum_d;
                    lines_q    <= lines_d;
                    line_pix_q <= line_end ? 11'd0 : line_pix_d;
                    if (line_end && lines_q == 10'd0)
                        hact_q <= line_pix_d;
                    if (vs_fall) begin
                        vact_q      <= lines_d;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a small 8x4 frame generator.
module tb_vga_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [2:0] address = 3'd0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       vga_clk = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
    logic [7:0] vga_r = 8'h00;

    int checks = 0;
    int errors = 0;

    vga_capture #(.HACTIVE(8), .VACTIVE(4)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .read(read), .address(address), .writedata(writedata),
        .readdata(readdata), .vga_clk(vga_clk), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_r(vga_r)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end else begin
            $display("ok   %s = %02h", tag, got);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // One pixel period: two system clocks, data set up while vga_clk is low.
    task automatic px(input logic vs, input logic blank, input logic hs, input logic [7:0] r);
        @(negedge clk);
        vga_clk = 1'b0; vga_vs = vs; vga_blank_n = blank; vga_hs = hs; vga_r = r;
        @(negedge clk);
        vga_clk = 1'b1;
    endtask

    // rmode: 0 const 01, 1 ramp x+1, 2 const FF. mid: 0 none, 1 ARM, 2 reset.
    task automatic frame(input int rmode, input int short_line, input int mid);
        logic [7:0] r;
        int npix;
        repeat (2) px(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (2) px(1'b1, 1'b0, 1'b1, 8'h00);
        for (int l = 0; l < 4; l++) begin
            npix = (l == short_line) ? 7 : 8;
            for (int x = 0; x < npix; x++) begin
                r = (rmode == 0) ? 8'h01 : (rmode == 1) ? 8'(x + 1) : 8'hFF;
                if (l == 2 && x == 0 && mid == 1) begin
                    chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 8'h01;
                end
                if (l == 2 && x == 0 && mid == 2)
                    reset = 1'b1;
                px(1'b1, 1'b1, 1'b1, r);
                chipselect = 1'b0; write = 1'b0; reset = 1'b0;
            end
            px(1'b1, 1'b0, 1'b1, 8'h00);
            repeat (2) px(1'b1, 1'b0, 1'b0, 8'h00);
            px(1'b1, 1'b0, 1'b1, 8'h00);
        end
        repeat (2) px(1'b1, 1'b0, 1'b1, 8'h00);
        repeat (2) px(1'b0, 1'b0, 1'b1, 8'h00);
        repeat (2) px(1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic check_all(input string pfx, input logic [7:0] st, input logic [10:0] hact,
                             input logic [9:0] vact, input logic [15:0] csum, input logic [7:0] fc);
        logic [7:0] d;
        reg_rd(3'd0, d); check_eq({pfx, "_status"}, d, st);
        reg_rd(3'd1, d); check_eq({pfx, "_hact_hi"}, d, {5'b0, hact[10:8]});
        reg_rd(3'd2, d); check_eq({pfx, "_hact_lo"}, d, hact[7:0]);
        reg_rd(3'd3, d); check_eq({pfx, "_vact_hi"}, d, {6'b0, vact[9:8]});
        reg_rd(3'd4, d); check_eq({pfx, "_vact_lo"}, d, vact[7:0]);
        reg_rd(3'd5, d); check_eq({pfx, "_csum_hi"}, d, csum[15:8]);
        reg_rd(3'd6, d); check_eq({pfx, "_csum_lo"}, d, csum[7:0]);
        reg_rd(3'd7, d); check_eq({pfx, "_frame_cnt"}, d, fc);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] short_st;
`ifdef VGA_CAP_ERRCHK_EN
        short_st = 8'h05;
`else
        short_st = 8'h01;
`endif
        do_reset();
        check_all("reset", 8'h00, 11'd0, 10'd0, 16'h0000, 8'd0);

        reg_wr(3'd0, 8'h01);
        reg_rd(3'd0, d); check_eq("armed_status", d, 8'h02);
        frame(0, -1, 0);
        check_all("f1", 8'h01, 11'd8, 10'd4, 16'h0020, 8'd1);

        reg_wr(3'd0, 8'h01);
        check_all("rearm", 8'h02, 11'd0, 10'd0, 16'h0000, 8'd1);
        frame(0, -1, 0);
        check_all("f2", 8'h01, 11'd8, 10'd4, 16'h0020, 8'd2);

        reg_wr(3'd0, 8'h01);
        frame(1, -1, 0);
        check_all("ramp", 8'h01, 11'd8, 10'd4, 16'h0090, 8'd3);

        reg_wr(3'd0, 8'h01);
        frame(0, -1, 1);
        check_all("midarm", 8'h01, 11'd8, 10'd4, 16'h0020, 8'd4);

        reg_wr(3'd0, 8'h01);
        frame(0, -1, 2);
        check_all("midrst", 8'h00, 11'd0, 10'd0, 16'h0000, 8'd0);

        reg_wr(3'd0, 8'h01);
        frame(0, -1, 0);
        check_all("postrst", 8'h01, 11'd8, 10'd4, 16'h0020, 8'd1);

        reg_wr(3'd0, 8'h01);
        frame(0, 1, 0);
        check_all("short", short_st, 11'd8, 10'd4, 16'h001F, 8'd2);

        do_reset();
        for (int f = 0; f < 256; f++) begin
            reg_wr(3'd0, 8'h01);
            frame(2, -1, 0);
            reg_rd(3'd5, d); check_eq($sformatf("ff%0d_csum_hi", f), d, 8'h1F);
            reg_rd(3'd6, d); check_eq($sformatf("ff%0d_csum_lo", f), d, 8'hE0);
        end
        reg_rd(3'd7, d); check_eq("wrap_frame_cnt", d, 8'h00);
        reg_rd(3'd0, d); check_eq("wrap_status", d, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
